// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller receiver.
package nes_pkg;

    localparam int NES_BITS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        CLK_HIGH = 3'd2,
        CLK_LOW  = 3'd3,
        DONE     = 3'd4
    } nes_state_t;

    // New bits enter at the MSB so the first bit read (A) ends up in bit 0.
    function automatic logic [NES_BITS-1:0] shift_in(input logic [NES_BITS-1:0] sr,
                                                     input logic pressed);
        return {pressed, sr[NES_BITS-1:1]};
    endfunction

endpackage

// File: rtl/nes_data_sync.sv
// Two-flop synchronizer for the controller data line; resets to the released level (1).
module nes_data_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/nes_receiver.sv
// NES controller poller: drives latch/clock, shifts in 8 buttons, reports an active-high word.
// Optional feature: define NES_DEBOUNCE_EN to require two matching polls before updating buttons.
module nes_receiver
    import nes_pkg::*;
#(
    parameter int HALF_PERIOD = 150
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int PW = $clog2(2 * HALF_PERIOD);
    localparam logic [PW-1:0] PH_ZERO    = PW'(0);
    localparam logic [PW-1:0] PH_ONE     = PW'(1);
    localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);

    nes_state_t    state_r;
    logic [PW-1:0] phase_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    sr_r;
    logic          data_s;
    logic          pressed_s;
`ifdef NES_DEBOUNCE_EN
    logic [7:0]    held_r;
`endif

    nes_data_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (nes_data),
        .q     (data_s)
    );

    assign pressed_s = ~data_s;

    // Poll sequencer: all pin and status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            phase_r   <= PH_ZERO;
            bit_cnt_r <= 3'd0;
            sr_r      <= 8'h00;
            nes_latch <= 1'b0;
            nes_clk   <= 1'b0;
            buttons   <= 8'h00;
            valid     <= 1'b0;
            busy      <= 1'b0;
`ifdef NES_DEBOUNCE_EN
            held_r    <= 8'h00;
`endif
        end else begin
            valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= LATCH;
                        phase_r   <= PH_ZERO;
                        bit_cnt_r <= 3'd0;
                        nes_latch <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_r == LATCH_LAST) begin
                        sr_r      <= shift_in(sr_r, pressed_s);
                        state_r   <= CLK_HIGH;
                        phase_r   <= PH_ZERO;
                        nes_latch <= 1'b0;
                        nes_clk   <= 1'b1;
                    end else begin
                        phase_r <= phase_r + PH_ONE;
                    end
                end
                CLK_HIGH: begin
                    // Sample at the end of the high phase, well after the controller has settled.
                    if (phase_r == HALF_LAST) begin
                        sr_r      <= shift_in(sr_r, pressed_s);
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        state_r   <= CLK_LOW;
                        phase_r   <= PH_ZERO;
                        nes_clk   <= 1'b0;
                    end else begin
                        phase_r <= phase_r + PH_ONE;
                    end
                end
                CLK_LOW: begin
                    if (phase_r == HALF_LAST) begin
                        phase_r <= PH_ZERO;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= DONE;
                            valid   <= 1'b1;
`ifdef NES_DEBOUNCE_EN
                            if (sr_r == held_r) begin
                                buttons <= sr_r;
                            end else begin
                                buttons <= buttons;
                            end
                            held_r <= sr_r;
`else
                            buttons <= sr_r;
`endif
                        end else begin
                            state_r <= CLK_HIGH;
                            nes_clk <= 1'b1;
                        end
                    end else begin
                        phase_r <= phase_r + PH_ONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    phase_r <= PH_ZERO;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    phase_r   <= PH_ZERO;
                    nes_latch <= 1'b0;
                    nes_clk   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_receiver.sv
// Scoreboard bench for nes_receiver with a behavioural NES controller model (HALF_PERIOD=4).
module tb_nes_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_clk;
    logic [7:0] buttons;
    logic       valid;
    logic       busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] raw_word = 8'hFF;
    logic [7:0] ctl_sr = 8'hFF;
    logic       ctl_clk_d = 1'b0;
    logic [7:0] held_m = 8'h00;
    logic [7:0] btn_m = 8'h00;

    nes_receiver #(.HALF_PERIOD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .nes_data  (nes_data),
        .nes_latch (nes_latch),
        .nes_clk   (nes_clk),
        .buttons   (buttons),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Controller: parallel load while latch is high, shift on rising nes_clk.
    always @(posedge clk) begin
        ctl_clk_d <= nes_clk;
        if (nes_latch) ctl_sr <= raw_word;
        else if (nes_clk && !ctl_clk_d) ctl_sr <= {1'b1, ctl_sr[7:1]};
    end
    assign nes_data = ctl_sr[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_valid: got buttons %0h expected no valid", buttons);
            end else begin
                check("buttons_word", {24'h0, buttons}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Issue one poll, optionally with extra start pulses at cycles x1/x2, and check its timing.
    task automatic poll(input logic [7:0] raw, input int x1, input int x2);
        int lat_n = 0, lat_rise = 0, clk_rise = 0, clk_n = 0, vcnt = 0, vcyc = 0;
        logic pl = 1'b0, pc = 1'b0, b1 = 1'b0, b65 = 1'b0, b66 = 1'b1;
        logic [7:0] word;
        raw_word = raw;
        word = ~raw;
`ifdef NES_DEBOUNCE_EN
        if (word == held_m) btn_m = word;
        held_m = word;
`else
        btn_m = word;
`endif
        exp_q.push_back(btn_m);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 72; c++) begin
            @(negedge clk);
            start = (c == x1) || (c == x2);
            if (nes_latch) lat_n++;
            if (nes_latch && !pl) lat_rise++;
            if (nes_clk) clk_n++;
            if (nes_clk && !pc) clk_rise++;
            pl = nes_latch;
            pc = nes_clk;
            if (valid) begin
                vcnt++;
                vcyc = c;
            end
            if (c == 1) b1 = busy;
            if (c == 65) b65 = busy;
            if (c == 66) b66 = busy;
        end
        start = 1'b0;
        check("latch_cycles", lat_n, 8);
        check("latch_pulses", lat_rise, 1);
        check("clk_pulses", clk_rise, 7);
        check("clk_high_cycles", clk_n, 28);
        check("valid_count", vcnt, 1);
        check("valid_cycle", vcyc, 65);
        check("busy_first", {31'h0, b1}, 1);
        check("busy_done", {31'h0, b65}, 1);
        check("busy_after", {31'h0, b66}, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        held_m = 8'h00;
        btn_m = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int changes;
        logic pl, pc, pv, pb;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_latch", {31'h0, nes_latch}, 0);
        check("rst_clk", {31'h0, nes_clk}, 0);
        check("rst_buttons", {24'h0, buttons}, 0);
        check("rst_valid", {31'h0, valid}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        rst_n = 1'b1;
        changes = 0;
        pl = nes_latch; pc = nes_clk; pv = valid; pb = busy;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (nes_latch !== pl || nes_clk !== pc || valid !== pv || busy !== pb) changes++;
            pl = nes_latch; pc = nes_clk; pv = valid; pb = busy;
        end
        check("idle_toggles", changes, 0);
        check("idle_buttons", {24'h0, buttons}, 0);

        // A + Up pressed, with rejected starts mid-poll and in DONE
        poll(8'hEE, 20, 65);
        poll(8'hEE, 0, 0);
        // All pressed, then none pressed
        poll(8'h00, 0, 0);
        poll(8'h00, 0, 0);
        poll(8'hFF, 0, 0);
        poll(8'hFF, 0, 0);

        // Mid-poll reset during the 4th clock pulse (high cycles 33..36)
        raw_word = 8'h5A;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (33) @(negedge clk);
        check("pre_reset_clk_high", {31'h0, nes_clk}, 1);
        #1 rst_n = 1'b0;
        held_m = 8'h00;
        btn_m = 8'h00;
        #1;
        check("mid_rst_latch", {31'h0, nes_latch}, 0);
        check("mid_rst_clk", {31'h0, nes_clk}, 0);
        check("mid_rst_busy", {31'h0, busy}, 0);
        check("mid_rst_valid", {31'h0, valid}, 0);
        check("mid_rst_buttons", {24'h0, buttons}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        poll(8'hEE, 0, 0);
        poll(8'hEE, 0, 0);

        // Sequence 01, 03, 03 from a clean reset
        pulse_reset();
        poll(8'hFE, 0, 0);
        poll(8'hFC, 0, 0);
        poll(8'hFC, 0, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
